life_stepper: RTL and testbench

//  Computes one Game-of-Life generation (B3/S23, toroidal board) per step request.

---
 rtl/life_stepper_pkg.sv | 37 +++
 rtl/life_stepper_if.sv | 32 +++
 rtl/life_word_rule.sv | 34 +++
 rtl/life_stepper.sv | 171 +++++++++++++++++
 tb/tb_life_stepper.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/life_stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : life_stepper_pkg
// Purpose  : Board geometry, address helpers and stepper state type.
// Revision : 1.0
// ============================================================================
package life_stepper_pkg;

    localparam int BOARD_SIZE        = 32;
    localparam int LOG_BOARD_SIZE    = 5;
    localparam int WORD_SIZE         = 8;
    localparam int LOG_WORD_SIZE     = 3;
    localparam int LOG_WORDS_PER_ROW = LOG_BOARD_SIZE - LOG_WORD_SIZE;
    localparam int WORDS_PER_ROW     = 1 << LOG_WORDS_PER_ROW;
    localparam int BANK_WORDS        = BOARD_SIZE * WORDS_PER_ROW;
    localparam int LOG_MAX_ADDR      = 1 + LOG_BOARD_SIZE + LOG_WORDS_PER_ROW;
    // Window columns per row: one wrap column either side of the row.
    localparam int COLS_PER_ROW      = WORDS_PER_ROW + 2;

    typedef logic [LOG_BOARD_SIZE-1:0]    pos_t;
    typedef logic [LOG_WORDS_PER_ROW-1:0] word_idx_t;
    typedef logic [LOG_MAX_ADDR-1:0]      addr_t;
    typedef logic [WORD_SIZE-1:0]         word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } stepper_state_t;

    // bank*BANK_WORDS + row*WORDS_PER_ROW + word with power-of-2 geometry.
    function automatic addr_t board_addr(input logic bank, input pos_t row, input word_idx_t word);
        return {bank, row, word};
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_stepper_if.sv
`default_nettype none
// ============================================================================
// Module   : life_stepper_if
// Purpose  : Stepper control, board RAM ports and renderer status bundle.
// Revision : 1.0
// ============================================================================
interface life_stepper_if;
    import life_stepper_pkg::*;

    logic  start_in;
    logic  step_en_in;
    word_t data_r_in;
    addr_t addr_r_out;
    addr_t addr_w_out;
    word_t data_w_out;
    logic  we_out;
    logic  bank_out;
    logic  busy_out;
    logic  done_out;

    modport master (
        input  start_in, step_en_in, data_r_in,
        output addr_r_out, addr_w_out, data_w_out, we_out, bank_out, busy_out, done_out
    );

    modport slave (
        output start_in, step_en_in, data_r_in,
        input  addr_r_out, addr_w_out, data_w_out, we_out, bank_out, busy_out, done_out
    );

endinterface
`default_nettype wire

// File: rtl/life_word_rule.sv
`default_nettype none
// ============================================================================
// Module   : life_word_rule
// Purpose  : B3/S23 next state for the centre word of a 3x3 word window.
// Revision : 1.0
// ============================================================================
module life_word_rule
    import life_stepper_pkg::*;
(
    input  wire [3*WORD_SIZE-1:0] i_up_row,
    input  wire [3*WORD_SIZE-1:0] i_mid_row,
    input  wire [3*WORD_SIZE-1:0] i_dn_row,
    output logic [WORD_SIZE-1:0]  o_next_word
);

    // Rows are {left, centre, right}; MSB is the leftmost cell, so the left
    // neighbour of a bit sits one position higher.
    for (genvar j = 0; j < WORD_SIZE; j++) begin : g_bit
        localparam int c_P = WORD_SIZE + j;
        logic [3:0] w_count;

        assign w_count = 4'(i_up_row[c_P+1])  + 4'(i_up_row[c_P])  + 4'(i_up_row[c_P-1])
                       + 4'(i_mid_row[c_P+1])                      + 4'(i_mid_row[c_P-1])
                       + 4'(i_dn_row[c_P+1])  + 4'(i_dn_row[c_P])  + 4'(i_dn_row[c_P-1]);

        assign o_next_word[j] = (w_count == 4'd3) | (i_mid_row[c_P] & (w_count == 4'd2));
    end

    wire w_unused = ^{i_up_row[3*WORD_SIZE-1:2*WORD_SIZE+1],  i_up_row[WORD_SIZE-2:0],
                      i_mid_row[3*WORD_SIZE-1:2*WORD_SIZE+1], i_mid_row[WORD_SIZE-2:0],
                      i_dn_row[3*WORD_SIZE-1:2*WORD_SIZE+1],  i_dn_row[WORD_SIZE-2:0]};

endmodule
`default_nettype wire

// File: rtl/life_stepper.sv
`default_nettype none
// ============================================================================
// Module   : life_stepper
// Purpose  : One toroidal B3/S23 generation per accepted step, read from the
//            current bank and written to the other one.
// Revision : 1.0
// ============================================================================
module life_stepper
    import life_stepper_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  wire            clk_130mhz,
    input  wire            rst_in,
    life_stepper_if.master bus
);

    localparam int         c_COL_W    = $clog2(COLS_PER_ROW);
    localparam int         c_LAT_W    = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [1:0] c_LAST_SUB = 2'd2;

    stepper_state_t             r_state;
    pos_t                       r_row;
    logic [c_COL_W-1:0]         r_col;
    logic [1:0]                 r_sub;
    logic [c_LAT_W-1:0]         r_lat;
    logic                       r_fetch_done;
    logic                       r_pend;
    addr_t                      r_pend_addr;
    word_t                      r_cap_up;
    word_t                      r_cap_mid;
    logic [2:0][WORD_SIZE-1:0]  r_left;
    logic [2:0][WORD_SIZE-1:0]  r_centre;
    logic [2:0][WORD_SIZE-1:0]  r_right;

    logic               w_capture;
    logic               w_col_end;
    logic               w_row_end;
    logic               w_last;
    logic [1:0]         w_next_sub;
    logic [c_COL_W-1:0] w_next_col;
    pos_t               w_next_row;
    word_t              w_next_word;

    // Window column index col holds board column col-1 (wrapping), row offset sub-1.
    function automatic addr_t read_addr(input logic bank, input pos_t row,
                                        input logic [1:0] sub, input logic [c_COL_W-1:0] col);
        pos_t      src_row;
        word_idx_t src_word;
        src_row  = row + pos_t'(sub) - pos_t'(1);
        src_word = word_idx_t'(col - c_COL_W'(1));
        return board_addr(bank, src_row, src_word);
    endfunction

    life_word_rule u_rule (
        .i_up_row    ({r_left[0], r_centre[0], r_right[0]}),
        .i_mid_row   ({r_left[1], r_centre[1], r_right[1]}),
        .i_dn_row    ({r_left[2], r_centre[2], r_right[2]}),
        .o_next_word (w_next_word)
    );

    assign w_capture = (r_state == FETCH) && !r_fetch_done && (r_lat == c_LAT_W'(READ_LATENCY));
    assign w_col_end = (r_sub == c_LAST_SUB);
    assign w_row_end = w_col_end && (r_col == c_COL_W'(COLS_PER_ROW - 1));
    assign w_last    = w_row_end && (r_row == pos_t'(BOARD_SIZE - 1));

    always_comb begin
        w_next_sub = w_col_end ? 2'd0 : r_sub + 2'd1;
        w_next_col = r_col;
        w_next_row = r_row;
        if (w_row_end) begin
            w_next_col = '0;
            w_next_row = r_row + pos_t'(1);
        end else if (w_col_end) begin
            w_next_col = r_col + c_COL_W'(1);
        end
    end

    always_ff @(posedge clk_130mhz) begin
        if (rst_in) begin
            r_state         <= IDLE;
            r_row           <= '0;
            r_col           <= '0;
            r_sub           <= '0;
            r_lat           <= '0;
            r_fetch_done    <= 1'b0;
            r_pend          <= 1'b0;
            r_pend_addr     <= '0;
            r_cap_up        <= '0;
            r_cap_mid       <= '0;
            r_left          <= '0;
            r_centre        <= '0;
            r_right         <= '0;
            bus.addr_r_out  <= '0;
            bus.addr_w_out  <= '0;
            bus.data_w_out  <= '0;
            bus.we_out      <= 1'b0;
            bus.bank_out    <= 1'b0;
            bus.busy_out    <= 1'b0;
            bus.done_out    <= 1'b0;
        end else begin
            // Writes trail the window shift by one cycle and overlap the next read.
            bus.we_out   <= r_pend;
            bus.done_out <= 1'b0;
            r_pend       <= 1'b0;
            if (r_pend) begin
                bus.addr_w_out <= r_pend_addr;
                bus.data_w_out <= w_next_word;
            end

            case (r_state)
                IDLE: begin
                    if (bus.start_in && bus.step_en_in) begin
                        r_state        <= FETCH;
                        bus.busy_out   <= 1'b1;
                        r_row          <= '0;
                        r_col          <= '0;
                        r_sub          <= '0;
                        r_lat          <= '0;
                        r_fetch_done   <= 1'b0;
                        bus.addr_r_out <= read_addr(bus.bank_out, '0, 2'd0, '0);
                    end
                end

                FETCH: begin
                    if (r_fetch_done) begin
                        r_state <= DONE;
                    end else if (w_capture) begin
                        r_lat <= '0;
                        case (r_sub)
                            2'd0:    r_cap_up  <= bus.data_r_in;
                            2'd1:    r_cap_mid <= bus.data_r_in;
                            default: begin
                                r_left   <= r_centre;
                                r_centre <= r_right;
                                r_right  <= {bus.data_r_in, r_cap_mid, r_cap_up};
                                // Window now spans board columns col-3..col-1.
                                if (r_col >= c_COL_W'(2)) begin
                                    r_pend      <= 1'b1;
                                    r_pend_addr <= board_addr(~bus.bank_out, r_row,
                                                              word_idx_t'(r_col - c_COL_W'(2)));
                                end
                            end
                        endcase
                        r_sub <= w_next_sub;
                        r_col <= w_next_col;
                        r_row <= w_next_row;
                        if (w_last) begin
                            r_fetch_done <= 1'b1;
                        end else begin
                            bus.addr_r_out <= read_addr(bus.bank_out, w_next_row, w_next_sub, w_next_col);
                        end
                    end else begin
                        r_lat <= r_lat + c_LAT_W'(1);
                    end
                end

                DONE: begin
                    bus.bank_out <= ~bus.bank_out;
                    bus.done_out <= 1'b1;
                    bus.busy_out <= 1'b0;
                    r_state      <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_life_stepper.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_stepper
// Purpose  : Directed and random generations against a cell-level reference.
// Revision : 1.0
// ============================================================================
module tb_life_stepper;
    import life_stepper_pkg::*;

    localparam int c_RL  = 2;
    localparam int c_LAT = BOARD_SIZE * (WORDS_PER_ROW + 2) * 3 * (c_RL + 1) + 2;

    logic clk_130mhz = 1'b0;
    logic rst_in;
    always #5 clk_130mhz = ~clk_130mhz;

    life_stepper_if bus ();

    life_stepper #(.READ_LATENCY(c_RL)) dut (
        .clk_130mhz (clk_130mhz),
        .rst_in     (rst_in),
        .bus        (bus)
    );

    // Board RAM: two-stage read pipeline, bench load port has priority.
    logic [7:0] mem [256];
    logic [7:0] rd_pipe;
    logic       ld_en;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;

    always @(posedge clk_130mhz) begin
        rd_pipe       <= mem[bus.addr_r_out];
        bus.data_r_in <= rd_pipe;
        if (ld_en)            mem[ld_addr]        <= ld_data;
        else if (bus.we_out)  mem[bus.addr_w_out] <= bus.data_w_out;
    end

    bit   cur [32][32];
    bit   nxt [32][32];
    logic cur_bank;
    int   errors;
    int   checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cur();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) cur[y][x] = 1'b0;
    endtask

    task automatic set_cell(input int y, input int x);
        cur[y][x] = 1'b1;
    endtask

    task automatic random_cur();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) cur[y][x] = ($urandom_range(2) == 0);
    endtask

    task automatic model_step();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dy != 0 || dx != 0) n += int'(cur[(y + dy + 32) % 32][(x + dx + 32) % 32]);
                nxt[y][x] = (n == 3) || (cur[y][x] && n == 2);
            end
    endtask

    function automatic logic [7:0] model_word(input int y, input int w);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[7-k] = cur[y][w*8+k];
        return v;
    endfunction

    function automatic int bank_pop(input logic b);
        int n;
        n = 0;
        for (int i = 0; i < 128; i++) n += $countones(mem[{b, 7'(i)}]);
        return n;
    endfunction

    task automatic load_cur(input logic b);
        for (int y = 0; y < 32; y++)
            for (int w = 0; w < 4; w++) begin
                @(negedge clk_130mhz);
                ld_en   = 1'b1;
                ld_addr = {b, 5'(y), 2'(w)};
                ld_data = model_word(y, w);
            end
        @(negedge clk_130mhz);
        ld_en = 1'b0;
    endtask

    task automatic check_bank(input logic b, input string tag);
        for (int y = 0; y < 32; y++)
            for (int w = 0; w < 4; w++)
                check($sformatf("%s[y%0d w%0d]", tag, y, w),
                      32'(mem[{b, 5'(y), 2'(w)}]), 32'(model_word(y, w)));
    endtask

    // One full generation; poke > 0 re-pulses start_in that many cycles in.
    task automatic do_step(input string tag, input int poke);
        int   elapsed;
        int   writes;
        int   bad_bank;
        int   dup;
        int   extra_done;
        int   wr_cnt [128];
        logic dst;

        dst = ~cur_bank;
        model_step();
        for (int i = 0; i < 128; i++) wr_cnt[i] = 0;
        writes = 0; bad_bank = 0; elapsed = 0;
        check({tag, " bank before"}, 32'(bus.bank_out), 32'(cur_bank));

        @(negedge clk_130mhz);
        bus.start_in   = 1'b1;
        bus.step_en_in = 1'b1;
        @(negedge clk_130mhz);
        bus.start_in   = 1'b0;
        check({tag, " busy"}, 32'(bus.busy_out), 32'd1);

        while (!bus.done_out && elapsed < 3000) begin
            @(negedge clk_130mhz);
            elapsed++;
            bus.start_in = (poke > 0 && elapsed == poke);
            if (bus.we_out) begin
                writes++;
                if (bus.addr_w_out[7] !== dst) bad_bank++;
                wr_cnt[int'(bus.addr_w_out[6:0])]++;
            end
        end
        bus.start_in = 1'b0;

        dup = 0;
        for (int i = 0; i < 128; i++) if (wr_cnt[i] != 1) dup++;
        check({tag, " latency"},      32'(elapsed),      32'(c_LAT));
        check({tag, " bank after"},   32'(bus.bank_out), 32'(dst));
        check({tag, " busy cleared"}, 32'(bus.busy_out), 32'd0);
        check({tag, " writes"},       32'(writes),       32'd128);
        check({tag, " write bank"},   32'(bad_bank),     32'd0);
        check({tag, " addr once"},    32'(dup),          32'd0);

        extra_done = 0;
        repeat (20) begin
            @(negedge clk_130mhz);
            if (bus.done_out) extra_done++;
        end
        check({tag, " single done"}, 32'(extra_done), 32'd0);

        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) cur[y][x] = nxt[y][x];
        cur_bank = dst;
        check_bank(dst, tag);
    endtask

    initial begin
        logic busy_seen;
        errors = 0;
        checks = 0;
        cur_bank = 1'b0;
        rst_in = 1'b1;
        bus.start_in = 1'b0;
        bus.step_en_in = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        repeat (3) @(negedge clk_130mhz);
        check("rst we",     32'(bus.we_out),     32'd0);
        check("rst busy",   32'(bus.busy_out),   32'd0);
        check("rst done",   32'(bus.done_out),   32'd0);
        check("rst bank",   32'(bus.bank_out),   32'd0);
        check("rst addr_r", 32'(bus.addr_r_out), 32'd0);
        check("rst addr_w", 32'(bus.addr_w_out), 32'd0);
        check("rst data_w", 32'(bus.data_w_out), 32'd0);
        rst_in = 1'b0;

        clear_cur();
        load_cur(1'b0);
        load_cur(1'b1);

        // Paused: start_in without step_en_in is dropped.
        @(negedge clk_130mhz);
        bus.start_in = 1'b1;
        @(negedge clk_130mhz);
        bus.start_in = 1'b0;
        busy_seen = bus.busy_out;
        repeat (10) begin
            @(negedge clk_130mhz);
            busy_seen = busy_seen | bus.busy_out;
        end
        check("paused busy", 32'(busy_seen), 32'd0);

        // Blinker oscillates horizontal <-> vertical.
        clear_cur();
        set_cell(5, 3); set_cell(5, 4); set_cell(5, 5);
        load_cur(cur_bank);
        do_step("blinker1", 0);
        check("blinker1 y4", 32'(mem[{1'b1, 5'd4, 2'd0}]), 32'h08);
        check("blinker1 y5", 32'(mem[{1'b1, 5'd5, 2'd0}]), 32'h08);
        check("blinker1 y6", 32'(mem[{1'b1, 5'd6, 2'd0}]), 32'h08);
        check("blinker1 pop", 32'(bank_pop(1'b1)), 32'd3);
        do_step("blinker2", 0);
        check("blinker2 y5", 32'(mem[{1'b0, 5'd5, 2'd0}]), 32'h1C);
        check("blinker2 pop", 32'(bank_pop(1'b0)), 32'd3);

        // Glider across the x=7/8 word boundary moves (+1,+1) in four steps.
        clear_cur();
        set_cell(1, 8); set_cell(2, 9); set_cell(3, 7); set_cell(3, 8); set_cell(3, 9);
        load_cur(cur_bank);
        for (int s = 0; s < 4; s++) do_step($sformatf("glider%0d", s), 0);
        clear_cur();
        set_cell(2, 9); set_cell(3, 10); set_cell(4, 8); set_cell(4, 9); set_cell(4, 10);
        check_bank(cur_bank, "glider shifted");

        // Block split over the four corners is a still life on the torus.
        clear_cur();
        set_cell(0, 0); set_cell(0, 31); set_cell(31, 0); set_cell(31, 31);
        load_cur(cur_bank);
        do_step("corner block", 0);
        check("corner y0 w0",  32'(mem[{cur_bank, 5'd0,  2'd0}]), 32'h80);
        check("corner y31 w3", 32'(mem[{cur_bank, 5'd31, 2'd3}]), 32'h01);

        clear_cur();
        set_cell(0, 0);
        load_cur(cur_bank);
        do_step("single cell", 0);
        check("single pop", 32'(bank_pop(cur_bank)), 32'd0);

        // Random soups, two generations each.
        for (int b = 0; b < 2; b++) begin
            random_cur();
            load_cur(cur_bank);
            do_step($sformatf("rand%0d a", b), 0);
            do_step($sformatf("rand%0d b", b), 0);
        end

        // Reset 100 cycles into a step, where a write would otherwise be issued.
        random_cur();
        load_cur(cur_bank);
        @(negedge clk_130mhz);
        bus.start_in = 1'b1;
        @(negedge clk_130mhz);
        bus.start_in = 1'b0;
        repeat (99) @(negedge clk_130mhz);
        rst_in = 1'b1;
        @(negedge clk_130mhz);
        rst_in = 1'b0;
        check("midrst we",   32'(bus.we_out),   32'd0);
        check("midrst bank", 32'(bus.bank_out), 32'd0);
        check("midrst busy", 32'(bus.busy_out), 32'd0);
        check("midrst done", 32'(bus.done_out), 32'd0);
        cur_bank = 1'b0;
        do_step("after reset", 0);

        do_step("busy poke", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
